// File: rtl/pad_control_seq_if.sv
// Register bus between the system interconnect and pad_control_seq.
// The master drives requests; the slave answers one cycle later.
interface pad_control_seq_if #(
    parameter int ADDR_W = 8
) ();
    logic              reg_valid;
    logic              reg_write;
    logic [ADDR_W-1:0] reg_addr;
    logic [31:0]       reg_wdata;
    logic              reg_rvalid;
    logic [31:0]       reg_rdata;
    logic              reg_err;

    modport master (
        output reg_valid, reg_write, reg_addr, reg_wdata,
        input  reg_rvalid, reg_rdata, reg_err
    );

    modport slave (
        input  reg_valid, reg_write, reg_addr, reg_wdata,
        output reg_rvalid, reg_rdata, reg_err
    );
endinterface

// File: rtl/pad_control_seq.sv
// Shadowed pad attribute/mux controller with a glitch-safe commit sequence.
// Optional macro PAD_CONTROL_SEQ_DONE_IRQ_EN builds the done_irq_o pulse register.
//
// state    | meaning
// S_IDLE   | waiting for COMMIT
// S_PRE    | changing pads held safe, old mux still active
// S_SWITCH | active muxes take the shadow values
// S_POST   | changing pads held safe, new mux active
// S_APPLY  | active attributes take the shadow values
module pad_control_seq #(
    parameter int                NUM_PAD     = 16,
    parameter int                ATTR_W      = 8,
    parameter int                MUX_W       = 4,
    parameter int                SAFE_CYCLES = 4,
    parameter int                ADDR_W      = 8,
    parameter logic [ATTR_W-1:0] ATTR_RST    = '0
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    pad_control_seq_if.slave          bus,
    output logic [NUM_PAD*ATTR_W-1:0] pad_attributes_o,
    output logic [NUM_PAD*MUX_W-1:0]  pad_muxes_o,
    output logic [NUM_PAD-1:0]        pad_safe_o,
    output logic                      busy_o,
    output logic                      done_irq_o
);
    typedef enum logic [2:0] {S_IDLE, S_PRE, S_SWITCH, S_POST, S_APPLY} state_t;

    localparam int            CW       = $clog2(SAFE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(SAFE_CYCLES - 1);

    state_t                      state_q, state_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic [NUM_PAD-1:0]          chg_q, chg_d, mux_diff, safe_d;
    logic [NUM_PAD*ATTR_W-1:0]   sh_attr;
    logic [NUM_PAD*MUX_W-1:0]    sh_mux;
    logic                        lock_q, err_q;
    logic [31:0]                 idx;
    logic                        busy, is_ctrl, is_attr, is_mux, wr, req_err, wr_ok, commit;
    logic [31:0]                 rdata_d;
    logic                        unused_bits;

    assign unused_bits = ^{bus.reg_addr[1:0], bus.reg_wdata};
    assign busy   = (state_q != S_IDLE);
    assign busy_o = busy;

    always_comb begin
        idx     = 32'(bus.reg_addr[ADDR_W-1:2]);
        is_ctrl = (idx == 32'd0);
        is_attr = (idx >= 32'd1) && (idx <= 32'(NUM_PAD));
        is_mux  = (idx > 32'(NUM_PAD)) && (idx <= 32'(2 * NUM_PAD));
        wr      = bus.reg_valid && bus.reg_write;
        req_err = bus.reg_valid && (
                      !(is_ctrl || is_attr || is_mux)
                   || (wr && (is_attr || is_mux) && (busy || lock_q))
                   || (wr && is_ctrl && bus.reg_wdata[0] && (busy || lock_q))
                   || (wr && is_ctrl && bus.reg_wdata[1] && busy));
        wr_ok   = wr && !req_err;
        commit  = wr_ok && is_ctrl && bus.reg_wdata[0];
    end

    always_comb begin
        rdata_d = '0;
        if (bus.reg_valid && !bus.reg_write) begin
            if (is_ctrl) rdata_d = {28'b0, err_q, busy, lock_q, 1'b0};
            for (int i = 0; i < NUM_PAD; i++) begin
                if (idx == 32'(i + 1))
                    rdata_d = 32'(sh_attr[i*ATTR_W +: ATTR_W]);
                if (idx == 32'(NUM_PAD + i + 1))
                    rdata_d = 32'(sh_mux[i*MUX_W +: MUX_W]);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_PAD; i++)
            mux_diff[i] = (sh_mux[i*MUX_W +: MUX_W] != pad_muxes_o[i*MUX_W +: MUX_W]);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        chg_d   = chg_q;
        case (state_q)
            S_IDLE: if (commit) begin
                chg_d = mux_diff;
                if (|mux_diff) begin
                    state_d = S_PRE;
                    cnt_d   = CNT_LOAD;
                end else begin
                    state_d = S_APPLY;
                end
            end
            S_PRE: begin
                if (cnt_q == '0) state_d = S_SWITCH;
                else             cnt_d   = cnt_q - CW'(1);
            end
            S_SWITCH: begin
                state_d = S_POST;
                cnt_d   = CNT_LOAD;
            end
            S_POST: begin
                if (cnt_q == '0) state_d = S_APPLY;
                else             cnt_d   = cnt_q - CW'(1);
            end
            S_APPLY: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Safe mask is registered so the pad drivers see a clean edge.
        safe_d = (state_d inside {S_PRE, S_SWITCH, S_POST}) ? chg_d : '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            chg_q      <= '0;
            pad_safe_o <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            chg_q      <= chg_d;
            pad_safe_o <= safe_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sh_attr          <= {NUM_PAD{ATTR_RST}};
            sh_mux           <= '0;
            pad_attributes_o <= {NUM_PAD{ATTR_RST}};
            pad_muxes_o      <= '0;
            lock_q           <= 1'b0;
            err_q            <= 1'b0;
            bus.reg_rvalid   <= 1'b0;
            bus.reg_rdata    <= '0;
            bus.reg_err      <= 1'b0;
        end else begin
            bus.reg_rvalid <= bus.reg_valid;
            bus.reg_rdata  <= rdata_d;
            bus.reg_err    <= req_err;
            if (req_err)
                err_q <= 1'b1;
            else if (wr_ok && is_ctrl && bus.reg_wdata[3])
                err_q <= 1'b0;
            if (wr_ok && is_ctrl && bus.reg_wdata[1])
                lock_q <= 1'b1;
            for (int i = 0; i < NUM_PAD; i++) begin
                if (wr_ok && idx == 32'(i + 1))
                    sh_attr[i*ATTR_W +: ATTR_W] <= bus.reg_wdata[ATTR_W-1:0];
                if (wr_ok && idx == 32'(NUM_PAD + i + 1))
                    sh_mux[i*MUX_W +: MUX_W] <= bus.reg_wdata[MUX_W-1:0];
            end
            // Shadow writes are blocked while busy, so only changing pads differ here.
            if (state_q == S_SWITCH) pad_muxes_o      <= sh_mux;
            if (state_q == S_APPLY)  pad_attributes_o <= sh_attr;
        end
    end

`ifdef PAD_CONTROL_SEQ_DONE_IRQ_EN
    logic done_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) done_q <= 1'b0;
        else         done_q <= (state_q == S_APPLY);
    end
    assign done_irq_o = done_q;
`else
    assign done_irq_o = 1'b0;
`endif
endmodule

// File: tb/tb_pad_control_seq.sv
// Directed self-checking bench for pad_control_seq (NUM_PAD=16, SAFE_CYCLES=4, ATTR_RST=0xC3).
module tb_pad_control_seq;
    localparam int         NUM_PAD = 16;
    localparam int         ATTR_W  = 8;
    localparam int         MUX_W   = 4;
    localparam int         SAFE    = 4;
    localparam int         ADDR_W  = 8;
    localparam logic [7:0] ARST    = 8'hC3;
`ifdef PAD_CONTROL_SEQ_DONE_IRQ_EN
    localparam logic EXP_DONE = 1'b1;
`else
    localparam logic EXP_DONE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pad_control_seq_if #(.ADDR_W(ADDR_W)) bus ();
    logic [NUM_PAD*ATTR_W-1:0] pad_attr;
    logic [NUM_PAD*MUX_W-1:0]  pad_mux;
    logic [NUM_PAD-1:0]        pad_safe;
    logic                      busy, done;

    pad_control_seq #(
        .NUM_PAD(NUM_PAD), .ATTR_W(ATTR_W), .MUX_W(MUX_W),
        .SAFE_CYCLES(SAFE), .ADDR_W(ADDR_W), .ATTR_RST(ARST)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus),
        .pad_attributes_o(pad_attr), .pad_muxes_o(pad_mux),
        .pad_safe_o(pad_safe), .busy_o(busy), .done_irq_o(done)
    );

    int n_chk  = 0;
    int n_fail = 0;
    logic [127:0] exp_attr;
    logic [63:0]  exp_mux;
    logic [15:0]  exp_safe;

    `define CHK(t, o, e) check(t, 128'(o), 128'(e))

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus_req(input logic w, input int idx, input logic [31:0] wd,
                           output logic [31:0] rd, output logic er);
        @(negedge clk);
        bus.reg_valid = 1'b1;
        bus.reg_write = w;
        bus.reg_addr  = 8'(idx * 4);
        bus.reg_wdata = wd;
        @(negedge clk);
        bus.reg_valid = 1'b0;
        bus.reg_write = 1'b0;
        `CHK("rvalid", bus.reg_rvalid, 1'b1);
        rd = bus.reg_rdata;
        er = bus.reg_err;
        if (w) `CHK("wr_rdata_zero", rd, 32'h0);
    endtask

    task automatic wr(input string tag, input int idx, input logic [31:0] d, input logic ee);
        logic [31:0] r;
        logic        e;
        bus_req(1'b1, idx, d, r, e);
        `CHK(tag, e, ee);
    endtask

    task automatic rd(input string tag, input int idx, input logic [31:0] ed, input logic ee);
        logic [31:0] r;
        logic        e;
        bus_req(1'b0, idx, 32'h0, r, e);
        `CHK({tag, "_data"}, r, ed);
        `CHK({tag, "_err"}, e, ee);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy === 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        `CHK("idle_timeout", busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.reg_valid = 1'b0;
        bus.reg_write = 1'b0;
        bus.reg_addr  = '0;
        bus.reg_wdata = '0;
        exp_attr = {16{ARST}};
        exp_mux  = '0;
        repeat (2) @(negedge clk);
        `CHK("rst_attr", pad_attr, exp_attr);
        `CHK("rst_mux", pad_mux, 64'h0);
        `CHK("rst_safe", pad_safe, 16'h0);
        `CHK("rst_busy", busy, 1'b0);
        `CHK("rst_done", done, 1'b0);
        `CHK("rst_rvalid", bus.reg_rvalid, 1'b0);
        `CHK("rst_rdata", bus.reg_rdata, 32'h0);
        `CHK("rst_err", bus.reg_err, 1'b0);
        rst_n = 1'b1;

        rd("rd_attr0", 1, 32'h0000_00C3, 1'b0);
        rd("rd_mux0", NUM_PAD + 1, 32'h0, 1'b0);
        @(negedge clk);
        `CHK("rvalid_drop", bus.reg_rvalid, 1'b0);

        wr("wr_attr3", 4, 32'h5A, 1'b0);
        wr("commit1", 0, 32'h1, 1'b0);
        `CHK("c1_busy_s1", busy, 1'b1);
        `CHK("c1_attr_s1", pad_attr, exp_attr);
        `CHK("c1_safe_s1", pad_safe, 16'h0);
        @(negedge clk);
        exp_attr[3*8 +: 8] = 8'h5A;
        `CHK("c1_busy_s2", busy, 1'b0);
        `CHK("c1_attr_s2", pad_attr, exp_attr);
        `CHK("c1_safe_s2", pad_safe, 16'h0);
        `CHK("c1_done_s2", done, EXP_DONE);
        @(negedge clk);
        `CHK("c1_done_s3", done, 1'b0);

        wr("wr_mux5", NUM_PAD + 1 + 5, 32'h2, 1'b0);
        wr("wr_attr5", 6, 32'h11, 1'b0);
        wr("commit2", 0, 32'h1, 1'b0);
        for (int k = 1; k <= 11; k++) begin
            if (k > 1) @(negedge clk);
            exp_safe = (k <= 9) ? 16'h0020 : 16'h0000;
            if (k == 6)  exp_mux[5*4 +: 4] = 4'h2;
            if (k == 11) exp_attr[5*8 +: 8] = 8'h11;
            `CHK("c2_safe", pad_safe, exp_safe);
            `CHK("c2_mux", pad_mux, exp_mux);
            `CHK("c2_attr", pad_attr, exp_attr);
            `CHK("c2_busy", busy, (k <= 10));
            `CHK("c2_done", done, ((k == 11) ? EXP_DONE : 1'b0));
            n_chk++;
            if (pad_safe !== exp_safe) begin
                n_fail++;
                $error("FAIL c2_safe_direct observed=%h expected=%h", pad_safe, exp_safe);
            end
            n_chk++;
            if (pad_mux !== exp_mux) begin
                n_fail++;
                $error("FAIL c2_mux_direct observed=%h expected=%h", pad_mux, exp_mux);
            end
        end

        wr("wr_mux5b", NUM_PAD + 1 + 5, 32'h7, 1'b0);
        wr("commit3", 0, 32'h1, 1'b0);
        wr("busy_shadow_wr", 1, 32'h99, 1'b1);
        wr("busy_commit", 0, 32'h1, 1'b1);
        rd("busy_ctrl", 0, 32'hC, 1'b0);
        rd("busy_shadow", 1, 32'hC3, 1'b0);
        wait_idle();
        exp_mux[5*4 +: 4] = 4'h7;
        `CHK("c3_mux", pad_mux, exp_mux);
        `CHK("c3_attr", pad_attr, exp_attr);
        wr("clr_err", 0, 32'h8, 1'b0);
        rd("ctrl_cleared", 0, 32'h0, 1'b0);

        wr("wr_mux2", NUM_PAD + 1 + 2, 32'h3, 1'b0);
        wr("commit4", 0, 32'h1, 1'b0);
        repeat (6) @(negedge clk);
        `CHK("post_safe", pad_safe, 16'h0004);
        `CHK("post_busy", busy, 1'b1);
        `CHK("post_mux2", pad_mux[2*4 +: 4], 4'h3);
        #2 rst_n = 1'b0;
        #1;
        `CHK("mid_rst_safe", pad_safe, 16'h0);
        `CHK("mid_rst_busy", busy, 1'b0);
        `CHK("mid_rst_mux", pad_mux, 64'h0);
        `CHK("mid_rst_attr", pad_attr, {16{ARST}});
        n_chk++;
        if (pad_safe !== 16'h0) begin
            n_fail++;
            $error("FAIL mid_rst_safe_direct observed=%h expected=%h", pad_safe, 16'h0);
        end
        n_chk++;
        if (busy !== 1'b0) begin
            n_fail++;
            $error("FAIL mid_rst_busy_direct observed=%h expected=%h", busy, 1'b0);
        end
        exp_attr = {16{ARST}};
        exp_mux  = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            `CHK("after_rst_done", done, 1'b0);
            `CHK("after_rst_busy", busy, 1'b0);
        end
        rd("after_rst_ctrl", 0, 32'h0, 1'b0);

        wr("set_lock", 0, 32'h2, 1'b0);
        rd("ctrl_lock", 0, 32'h2, 1'b0);
        wr("lock_shadow_wr", 1, 32'h77, 1'b1);
        wr("lock_commit", 0, 32'h1, 1'b1);
        @(negedge clk);
        `CHK("lock_busy", busy, 1'b0);
        `CHK("lock_attr", pad_attr, exp_attr);
        `CHK("lock_mux", pad_mux, exp_mux);
        rd("lock_shadow", 1, 32'hC3, 1'b0);
        rd("unmapped", 2 * NUM_PAD + 1, 32'h0, 1'b1);
        rd("ctrl_lock_err", 0, 32'hA, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pad_control_seq.md
Name: pad_control_seq

Overview:
- Parametrised successor to the fixed-map pad controller.
- Holds per-pad attribute and mux settings in shadow registers, written over a simple register bus.
- On a COMMIT request, applies the shadow settings atomically through a glitch-safe sequence: pads whose mux changes are forced to a safe state for a programmable guard period before and after the mux switch.
- Sits between the system register bus and the pad ring; outputs drive pad cells directly.

Parameters:
- NUM_PAD, 16, number of pads controlled (1..64).
- ATTR_W, 8, attribute bits per pad.
- MUX_W, 4, mux select bits per pad.
- SAFE_CYCLES, 4, guard cycles before and after a mux switch (>=1).
- ADDR_W, 8, byte address width; must satisfy 2^(ADDR_W-2) >= 2*NUM_PAD+1.
- ATTR_RST, 0, reset value of every pad attribute (ATTR_W bits).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- reg_valid_i  in  1  bus request valid
- reg_write_i  in  1  1 = write, 0 = read
- reg_addr_i  in  ADDR_W  byte address; bits [1:0] ignored
- reg_wdata_i  in  32  write data
- reg_rvalid_o  out  1  response valid, one cycle after request
- reg_rdata_o  out  32  read data, valid with reg_rvalid_o
- reg_err_o  out  1  error response, valid with reg_rvalid_o
- pad_attributes_o  out  NUM_PAD*ATTR_W  active attributes, pad i at [i*ATTR_W +: ATTR_W]
- pad_muxes_o  out  NUM_PAD*MUX_W  active mux selects
- pad_safe_o  out  NUM_PAD  1 = pad forced to safe state (output driver off)
- busy_o  out  1  commit sequence in progress
- done_irq_o  out  1  one-cycle pulse at sequence end

Behaviour:
- Word index idx = reg_addr_i[ADDR_W-1:2].
  - idx 0 = CTRL: write bit0 COMMIT (self-clearing), bit1 LOCK (sticky until reset), bit3 clears ERR. Read returns {28'b0, ERR, BUSY, LOCK, 0}.
  - idx 1..NUM_PAD = shadow attribute of pad idx-1.
  - idx NUM_PAD+1..2*NUM_PAD = shadow mux of pad idx-NUM_PAD-1.
  - Reads are zero-extended; writes use the low ATTR_W/MUX_W bits.
- Bus accepts one request per cycle, with no backpressure. reg_rvalid_o rises exactly 1 cycle after reg_valid_i; reg_rdata_o is 0 for writes.
- reg_err_o=1 and ERR sticky set, with no state change, on any of:
  - unmapped idx;
  - shadow write while BUSY or LOCK;
  - COMMIT while BUSY or LOCK;
  - LOCK write while BUSY.
- Reads are always allowed.
- Reset values:
  - Shadow and active attributes = ATTR_RST; shadow and active muxes = 0.
  - pad_safe_o=0, busy_o=0, done_irq_o=0, reg_rvalid_o=0, reg_rdata_o=0, reg_err_o=0, LOCK=0, ERR=0.
- On COMMIT, latch chg[i] = (shadow_mux[i] != active_mux[i]).
- FSM:
  - IDLE: on accepted COMMIT, go to PRE if any chg, else to APPLY.
  - PRE: pad_safe_o=chg. Counter runs SAFE_CYCLES cycles, then go to SWITCH.
  - SWITCH: 1 cycle; active_mux <= shadow_mux; pad_safe_o=chg.
  - POST: pad_safe_o=chg for SAFE_CYCLES cycles.
  - APPLY: 1 cycle; active_attr <= shadow_attr for all pads; pad_safe_o=0 next cycle. done_irq_o pulses next cycle; return to IDLE.
- busy_o=1 in every state except IDLE, starting the cycle after COMMIT is accepted.
- Latency from COMMIT acceptance to attributes visible:
  - no mux change: 2 cycles;
  - with mux change: 2*SAFE_CYCLES+3 cycles.
- Unchanged pads keep pad_safe_o=0 throughout and keep their old attributes until APPLY.
- Active outputs are registers, so they are glitch-free.
- Reset asserted mid-sequence: all state returns to reset values immediately (asynchronous); the sequence is abandoned.

Optional Feature:
- Macro PAD_CONTROL_SEQ_DONE_IRQ_EN.
- Defined: done_irq_o pulses as described.
- Undefined: done_irq_o is tied to 0, and the pulse register is not built.
- All other behaviour is identical in both cases.

Test Plan:
- Reset, then read idx 1 and idx NUM_PAD+1 -> rdata=ATTR_RST and 0; all pad outputs at reset values; rvalid one cycle after valid.
- Write attr pad3=0x5A (no mux change), COMMIT -> busy 1 cycle, pad_attributes_o[pad3]=0x5A 2 cycles after commit, pad_safe_o stays 0, done_irq 1 pulse.
- Write mux pad5=2, attr pad5=0x11, COMMIT (SAFE_CYCLES=4):
  - pad_safe_o[5]=1 for exactly 4+1+4 cycles;
  - pad_muxes_o[5]=2 from SWITCH onward;
  - attribute applied at APPLY, total 11 cycles;
  - other pad_safe_o bits stay 0.
- During busy: write shadow and issue a second COMMIT -> reg_err_o=1 on both, ERR=1, shadow unchanged, sequence completes normally; CTRL bit3 write clears ERR.
- Set LOCK, then write shadow and COMMIT -> both errored, outputs unchanged; read unmapped idx 2*NUM_PAD+1 -> err=1, rdata=0.
- Assert rst_ni during POST -> pad_safe_o, busy_o and muxes return to reset values immediately; no done_irq after release.
